// File: rtl/lsu_dmem_port_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface lsu_dmem_port_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_dmem_port.sv
// Load/store unit: turns one ALU-addressed load/store into a req/ack bus transaction,
// stalling the core until it completes, times out, or is rejected as illegal.
module lsu_dmem_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_c,
    input  logic [31:0] rf_rD2,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_exc,
    lsu_dmem_port_if.master dmem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        access, illegal, start, timeout_hit;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, rd_shift, rd_fmt;

    assign access = mem_rd | mem_wr;
    assign start  = (state == IDLE) && access && !illegal;

    always_comb begin
        illegal = 1'b0;
        if (mem_rd && mem_wr)
            illegal = 1'b1;
        else if (mem_rd)
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        else if (mem_wr)
            illegal = (funct3 >= 3'b011);
        // Width checks share funct3[1:0] encoding between loads and stores.
        if (funct3[1:0] == 2'b01 && alu_c[0])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && alu_c[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = rf_rD2;
        case (funct3[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << alu_c[1:0];
                wdata_fmt = {4{rf_rD2[7:0]}};
            end
            2'b01: begin
                be_fmt    = alu_c[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{rf_rD2[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = dmem.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        rd_fmt = dmem.dmem_rdata;
        case (f3_q)
            3'b000:  rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  rd_fmt = {24'h0, rd_shift[7:0]};
            3'b001:  rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  rd_fmt = {16'h0, rd_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        lsu_stall   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                    lsu_stall = 1'b1;
                end
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    state_nxt = DONE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 8'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            is_load_q  <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            lsu_exc    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            lsu_exc    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (access && illegal)
                        lsu_exc <= 1'b1;
                    if (start) begin
                        req_q     <= 1'b1;
                        we_q      <= mem_wr;
                        addr_q    <= {alu_c[31:2], 2'b00};
                        be_q      <= mem_wr ? be_fmt : 4'b0000;
                        wdata_q   <= wdata_fmt;
                        f3_q      <= funct3;
                        off_q     <= alu_c[1:0];
                        is_load_q <= mem_rd;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (state_nxt == DONE) begin
                        req_q      <= 1'b0;
                        load_valid <= is_load_q;
                        if (timeout_hit) begin
                            load_data <= 32'd0;
                            lsu_exc   <= 1'b1;
                        end else if (is_load_q) begin
                            load_data <= rd_fmt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule
